param_fifo: RTL and testbench
=============================

PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, storage entries; SHALL be a power of two, >=2.
REQ-003 Parameter AF_LEVEL, default DEPTH-2, almost_full threshold in entries.
REQ-004 Parameter AE_LEVEL, default 2, almost_empty threshold in entries.
REQ-005 Parameter FWFT, default 0, read mode select: 0 = registered read, 1 = first-word-fall-through.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 write  in  1  write request.
REQ-009 read  in  1  read request.
REQ-010 din  in  DATA_W  write data.
REQ-011 dout  out  DATA_W  read data.
REQ-012 full / empty  out  1 each  status flags.
REQ-013 almost_full / almost_empty  out  1 each  threshold flags.
REQ-014 count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-015 overflow / underflow  out  1 each  sticky error flags.

Function
REQ-016 Write accepted iff write=1 and full=0; accepted word goes to mem[wptr], wptr increments.
REQ-017 Read accepted iff read=1 and empty=0; rptr increments.
REQ-018 Accept decisions use flags registered at start of cycle; no full-bypass, no empty-bypass.
REQ-019 Write and read both accepted in one cycle: both pointers advance, count unchanged.
REQ-020 Write-only accepted: count+1; read-only accepted: count-1; neither: count held.
REQ-021 Pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 with no gap.
REQ-022 empty = (count==0); full = (count==DEPTH); both combinational from count.
REQ-023 almost_full = (count >= AF_LEVEL); almost_empty = (count <= AE_LEVEL).
REQ-024 FWFT=0: dout loads mem[rptr] on the edge a read is accepted (1-cycle latency); otherwise holds last value.
REQ-025 FWFT=1: dout continuously presents mem[rptr] while empty=0; read accepts/pops that word; value while empty is don't-care.
REQ-026 overflow sets on any cycle with write=1 and full=1; underflow sets on read=1 and empty=1; both stay set until reset.
REQ-027 Rejected requests change no pointer, count or memory.

Reset
REQ-028 reset=1 at an edge: wptr=0, rptr=0, count=0, dout=0, overflow=0, underflow=0; dominates concurrent write/read.
REQ-029 After reset: empty=1, full=0, almost_empty=1, almost_full=0.
REQ-030 Memory contents are not reset; reset mid-operation discards all stored words.

Structure
REQ-031 Package fifo_pkg holds default DATA_W/DEPTH constants and a count-width function; no typedefs otherwise.
REQ-032 Storage lives in sub-module param_fifo_mem (1 write port, 1 async read port, no reset); control, flags and counters stay in param_fifo.
REQ-033 Elaboration SHALL fail if DEPTH is not a power of two or AE_LEVEL >= AF_LEVEL.

Verification (DATA_W=8, DEPTH=16)
REQ-034 Reset, write 16 words 0x00..0x0F -> full=1 and count=16 after 16th edge; 17th write sets overflow, data unchanged.
REQ-035 Read 16 from full, FWFT=0 -> dout 0x00..0x0F, each one cycle after its read; empty=1 after last; one more read sets underflow.
REQ-036 Fill 8, then read+write together 20 cycles -> count stays 8, output order preserved across pointer wrap 15->0.
REQ-037 count crossing 14 -> almost_full rises at count=14; falling to 2 -> almost_empty rises at count=2.
REQ-038 FWFT=1, write 0xA5 into empty FIFO -> dout=0xA5 the cycle after the write, before any read; read -> empty=1.
REQ-039 Fill 5, assert reset with write=1 -> count=0, empty=1, dout=0x00, overflow/underflow=0 after the edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helpers for the parameterised FIFO family.
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  // Occupancy must represent 0..depth inclusive, hence one bit over the address.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/param_fifo_mem.sv
// FIFO storage array: one synchronous write port, one asynchronous read port, no reset.
module param_fifo_mem #(
  parameter int  DATA_W = 8,
  parameter int  DEPTH  = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_fifo.sv
// Single-clock parameterised FIFO: pointer/count control, status flags, sticky errors
// and a selectable registered or first-word-fall-through read path.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    write,
  input  logic                    read,
  input  logic [DATA_W-1:0]       din,
  output logic [DATA_W-1:0]       dout,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int            AW     = $clog2(DEPTH);
  localparam int            CW     = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "param_fifo: DEPTH must be a power of two and at least 2");
  end
  if (AE_LEVEL >= AF_LEVEL) begin : g_bad_levels
    $fatal(1, "param_fifo: AE_LEVEL must be below AF_LEVEL");
  end

  function automatic logic [CW-1:0] next_count(input logic [CW-1:0] c,
                                               input logic          inc,
                                               input logic          dec);
    case ({inc, dec})
      2'b10:   return c + CW'(1);
      2'b01:   return c - CW'(1);
      default: return c;
    endcase
  endfunction

  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [CW-1:0]     count_q;
  logic              ovf_q;
  logic              unf_q;
  logic              wr_acc;
  logic              rd_acc;
  logic [DATA_W-1:0] rd_word;

  // Accept decisions see only the flags held at the start of the cycle.
  assign empty        = (count_q == '0);
  assign full         = (count_q == FULL_C);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign wr_acc       = write && !full;
  assign rd_acc       = read && !empty;

  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + AW'(1);
      if (rd_acc) rptr <= rptr + AW'(1);
      count_q <= next_count(count_q, wr_acc, rd_acc);
      if (write && full)  ovf_q <= 1'b1;
      if (read && empty)  unf_q <= 1'b1;
    end
  end

  param_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr),
    .wdata (din),
    .raddr (rptr),
    .rdata (rd_word)
  );

  // Read stage: head word either falls through or is captured on an accepted read.
  if (FWFT != 0) begin : g_fwft
    assign dout = empty ? '0 : rd_word;
  end else begin : g_reg
    logic [DATA_W-1:0] dout_p1;
    always_ff @(posedge clk) begin
      if (reset)       dout_p1 <= '0;
      else if (rd_acc) dout_p1 <= rd_word;
    end
    assign dout = dout_p1;
  end

endmodule

// File: tb/tb_param_fifo.sv
// Bench for param_fifo: registered-read and FWFT instances share stimulus and are
// checked every cycle against a queue model, plus directed literal checks.
module tb_param_fifo;

  localparam int DW = 8;
  localparam int DP = 16;
  localparam int AF = 14;
  localparam int AE = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          write = 1'b0;
  logic          read = 1'b0;
  logic [DW-1:0] din = '0;

  logic [DW-1:0] d0_dout, d1_dout;
  logic          d0_full, d0_empty, d0_af, d0_ae, d0_ovf, d0_unf;
  logic          d1_full, d1_empty, d1_af, d1_ae, d1_ovf, d1_unf;
  logic [4:0]    d0_count, d1_count;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout0 = '0;
  bit            m_ovf = 1'b0;
  bit            m_unf = 1'b0;

  always #5 clk = ~clk;

  param_fifo #(.DATA_W(DW), .DEPTH(DP), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) dut0 (
    .clk(clk), .reset(reset), .write(write), .read(read), .din(din), .dout(d0_dout),
    .full(d0_full), .empty(d0_empty), .almost_full(d0_af), .almost_empty(d0_ae),
    .count(d0_count), .overflow(d0_ovf), .underflow(d0_unf)
  );

  param_fifo #(.DATA_W(DW), .DEPTH(DP), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) dut1 (
    .clk(clk), .reset(reset), .write(write), .read(read), .din(din), .dout(d1_dout),
    .full(d1_full), .empty(d1_empty), .almost_full(d1_af), .almost_empty(d1_ae),
    .count(d1_count), .overflow(d1_ovf), .underflow(d1_unf)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue updated by the acceptance rules at each rising edge.
  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_dout0 = '0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
    end else begin
      bit f, e;
      f = (q.size() == DP);
      e = (q.size() == 0);
      if (write && f) m_ovf = 1'b1;
      if (read && e)  m_unf = 1'b1;
      if (read && !e)  m_dout0 = q.pop_front();
      if (write && !f) q.push_back(din);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int n;
      n = q.size();
      chk("count0", d0_count, n);
      chk("count1", d1_count, n);
      chk("empty0", d0_empty, n == 0);
      chk("empty1", d1_empty, n == 0);
      chk("full0", d0_full, n == DP);
      chk("full1", d1_full, n == DP);
      chk("afull0", d0_af, n >= AF);
      chk("afull1", d1_af, n >= AF);
      chk("aempty0", d0_ae, n <= AE);
      chk("aempty1", d1_ae, n <= AE);
      chk("ovf0", d0_ovf, m_ovf);
      chk("ovf1", d1_ovf, m_ovf);
      chk("unf0", d0_unf, m_unf);
      chk("unf1", d1_unf, m_unf);
      chk("dout0", d0_dout, m_dout0);
      if (n != 0) chk("dout1_head", d1_dout, q[0]);
    end
  end

  // Drive at the falling edge, let one rising edge pass, return at the next falling edge.
  task automatic cyc(input bit r, input bit w, input bit rd, input logic [DW-1:0] d);
    reset = r;
    write = w;
    read  = rd;
    din   = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    cyc(1, 0, 0, 8'h00);
    cyc(1, 1, 1, 8'h33);
    chk_en = 1'b1;
    chk("rst_count", d0_count, 0);
    chk("rst_empty", d0_empty, 1);
    chk("rst_full", d0_full, 0);
    chk("rst_ae", d0_ae, 1);
    chk("rst_af", d0_af, 0);
    chk("rst_dout", d0_dout, 0);
    chk("rst_ovf", d0_ovf, 0);
    chk("rst_unf", d0_unf, 0);

    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, 0, 8'(i));
      chk("fill_count", d0_count, i + 1);
      chk("fill_af", d0_af, (i + 1) >= 14);
    end
    chk("fill_full", d0_full, 1);
    cyc(0, 1, 0, 8'hFF);
    chk("ovf_set", d0_ovf, 1);
    chk("ovf_count", d0_count, 16);

    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 1, 8'h00);
      chk("drain_dout", d0_dout, i);
      chk("drain_ae", d0_ae, (15 - i) <= 2);
    end
    chk("drain_empty", d0_empty, 1);
    cyc(0, 0, 1, 8'h00);
    chk("unf_set", d0_unf, 1);
    chk("unf_dout_hold", d0_dout, 8'h0F);

    cyc(1, 0, 0, 8'h00);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 8'(8'h20 + i));
    for (int k = 0; k < 20; k++) begin
      cyc(0, 1, 1, 8'(8'h40 + k));
      chk("wrap_count", d0_count, 8);
      chk("wrap_dout", d0_dout, (k < 8) ? (8'h20 + k) : (8'h40 + k - 8));
    end

    cyc(1, 0, 0, 8'h00);
    cyc(0, 1, 0, 8'hA5);
    chk("fwft_dout", d1_dout, 8'hA5);
    chk("fwft_nempty", d1_empty, 0);
    cyc(0, 0, 1, 8'h00);
    chk("fwft_empty", d1_empty, 1);
    chk("fwft_reg_dout", d0_dout, 8'hA5);

    cyc(0, 0, 1, 8'h00);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 8'(8'h70 + i));
    chk("pre_rst_unf", d0_unf, 1);
    cyc(1, 1, 0, 8'h99);
    chk("mid_rst_count", d0_count, 0);
    chk("mid_rst_empty", d0_empty, 1);
    chk("mid_rst_dout", d0_dout, 0);
    chk("mid_rst_ovf", d0_ovf, 0);
    chk("mid_rst_unf", d0_unf, 0);

    for (int blk = 0; blk < 30; blk++) begin
      int wp, rp;
      case (blk % 3)
        0:       begin wp = 80; rp = 20; end
        1:       begin wp = 20; rp = 80; end
        default: begin wp = 55; rp = 50; end
      endcase
      for (int c = 0; c < 100; c++) begin
        cyc(($urandom_range(299) == 0),
            ($urandom_range(99) < wp),
            ($urandom_range(99) < rp),
            8'($urandom));
      end
    end

    cyc(0, 0, 0, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
